// File: rtl/seqdiv32_16.sv
// seqdiv32_16: sequential restoring divider, 32-bit dividend by 16-bit
// divisor, one quotient bit per cycle, MSB first.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (N dividend, D divisor)
//   out_valid/out_ready result handshake (Q quotient, Rm remainder,
//                       dz divide-by-zero flag)
//
// Optional macro SEQDIV32_16_OUT_REG_EN adds one result register stage
// between the DONE state and the outputs (all latencies +1 cycle).

module seqdiv32_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] N,
    input  logic [15:0] D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Q,
    output logic [15:0] Rm,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    // q_r shifts dividend bits out the top and quotient bits in the bottom.
    logic [31:0] q_r;
    logic [15:0] rem_r;
    logic [15:0] d_r;
    logic        dz_r;
    logic [4:0]  cnt;
    // Result-ready flag inside DONE. Set on the edge that finishes the
    // last iteration, or one edge after entering DONE for D=0, so the
    // D=0 result appears one cycle after acceptance.
    logic        vld;
    logic        fire;

    logic [16:0] part;
    logic [16:0] diff;
    logic        qbit;
    logic        last_iter;

    // rem_r < d_r always holds, so part < 2*d_r. A 17-bit wrapped
    // difference then has bit 16 set exactly when the subtract borrows.
    assign part      = {rem_r, q_r[31]};
    assign diff      = part - {1'b0, d_r};
    assign qbit      = ~diff[16];
    assign last_iter = (cnt == 5'd31);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = (D == 16'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (fire) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Working registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r   <= 32'd0;
            rem_r <= 16'd0;
            d_r   <= 16'd0;
            dz_r  <= 1'b0;
            cnt   <= 5'd0;
            vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_r <= D;
                        cnt <= 5'd0;
                        vld <= 1'b0;
                        if (D == 16'd0) begin
                            q_r   <= 32'hFFFF_FFFF;
                            rem_r <= N[15:0];
                            dz_r  <= 1'b1;
                        end else begin
                            q_r   <= N;
                            rem_r <= 16'd0;
                            dz_r  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    q_r   <= {q_r[30:0], qbit};
                    rem_r <= qbit ? diff[15:0] : part[15:0];
                    cnt   <= cnt + 5'd1;
                    if (last_iter) begin
                        vld <= 1'b1;
                    end
                end
                DONE: begin
                    vld <= ~fire;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQDIV32_16_OUT_REG_EN
    logic        ov_r;
    logic [31:0] q_o;
    logic [15:0] rm_o;
    logic        dz_o;

    // Capture the result once when it becomes ready; hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_r <= 1'b0;
            q_o  <= 32'd0;
            rm_o <= 16'd0;
            dz_o <= 1'b0;
        end else if (fire) begin
            ov_r <= 1'b0;
        end else if (vld && !ov_r) begin
            ov_r <= 1'b1;
            q_o  <= q_r;
            rm_o <= rem_r;
            dz_o <= dz_r;
        end
    end

    assign fire      = ov_r & out_ready;
    assign out_valid = ov_r;
    assign Q         = q_o;
    assign Rm        = rm_o;
    assign dz        = dz_o;
`else
    assign fire      = vld & out_ready;
    assign out_valid = vld;
    assign Q         = q_r;
    assign Rm        = rem_r;
    assign dz        = dz_r;
`endif

endmodule

// File: tb/tb_seqdiv32_16.sv
// tb_seqdiv32_16: self-checking bench for seqdiv32_16 with directed
// vectors, handshake/reset corner sequences and a random run.

module tb_seqdiv32_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] N;
    logic [15:0] D;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Q;
    logic [15:0] Rm;
    logic        dz;

    int checks = 0;
    int errors = 0;

`ifdef SEQDIV32_16_OUT_REG_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    seqdiv32_16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .N         (N),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .Rm        (Rm),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] n;
        logic [15:0] d;
        logic [31:0] q;
        logic [15:0] rm;
        logic        dz;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer division.
    function automatic logic [31:0] ref_q(input logic [31:0] n,
                                          input logic [15:0] d);
        if (d == 16'd0) return 32'hFFFF_FFFF;
        return n / {16'd0, d};
    endfunction

    function automatic logic [15:0] ref_rm(input logic [31:0] n,
                                           input logic [15:0] d);
        logic [31:0] r;
        if (d == 16'd0) return n[15:0];
        r = n % {16'd0, d};
        return r[15:0];
    endfunction

    function automatic int ref_lat(input logic [15:0] d);
        return ((d == 16'd0) ? 1 : 32) + XL;
    endfunction

    // Present operands for one edge, then scramble the input bus.
    task automatic issue(input logic [31:0] n, input logic [15:0] d);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        N = n;
        D = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        N = $urandom;
        D = 16'($urandom);
    endtask

    // Wait for the result (counting edges since acceptance), check it,
    // hold out_ready low for 'stall' cycles, then take it.
    task automatic collect(input string tag,
                           input logic [31:0] eq, input logic [15:0] erm,
                           input logic edz, input int elat,
                           input int stall, input bit hold,
                           input logic [31:0] hn, input logic [15:0] hd);
        int lat;
        lat = 0;
        while (!out_valid && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"}, Q, eq);
        chk({tag, "_rm"}, {16'd0, Rm}, {16'd0, erm});
        chk({tag, "_dz"}, {31'd0, dz}, {31'd0, edz});
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (hold) begin
                in_valid = 1'b1;
                N = hn;
                D = hd;
            end
            @(posedge clk);
            #1;
            chk({tag, "_hold_q"}, Q, eq);
            chk({tag, "_hold_rm"}, {16'd0, Rm}, {16'd0, erm});
            chk({tag, "_hold_ov"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_ir"}, {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ir_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        logic [31:0] rn;
        logic [15:0] rd;

        tv[0] = '{32'd100,        16'd7,      32'd14,         16'd2,      1'b0};
        tv[1] = '{32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'd0,      1'b0};
        tv[2] = '{32'hFFFF_FFFF,  16'd1,      32'hFFFF_FFFF,  16'd0,      1'b0};
        tv[3] = '{32'd5,          16'd10,     32'd0,          16'd5,      1'b0};
        tv[4] = '{32'h1234_5678,  16'd0,      32'hFFFF_FFFF,  16'h5678,   1'b1};
        tv[5] = '{32'd1000,       16'd3,      32'd333,        16'd1,      1'b0};
        tv[6] = '{32'd0,          16'd5,      32'd0,          16'd0,      1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        N = 32'd0;
        D = 16'd0;
        #12;
        chk("rst_ir", {31'd0, in_ready}, 32'd1);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_q", Q, 32'd0);
        chk("rst_rm", {16'd0, Rm}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors; first one accepted on first edge after reset.
        for (int i = 0; i < 7; i++) begin
            issue(tv[i].n, tv[i].d);
            collect($sformatf("vec%0d", i), tv[i].q, tv[i].rm, tv[i].dz,
                    ref_lat(tv[i].d), i % 3, 1'b0, 32'd0, 16'd0);
        end

        // Result held 5 cycles while new operands wait on in_valid.
        issue(32'd100, 16'd7);
        collect("hold", 32'd14, 16'd2, 1'b0, 32 + XL, 5, 1'b1,
                32'd77, 16'd5);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("hold_accept", {31'd0, in_ready}, 32'd0);
        collect("after_hold", 32'd15, 16'd2, 1'b0, 32 + XL, 0, 1'b0,
                32'd0, 16'd0);

        // Reset mid-calculation aborts; no ghost result afterwards.
        issue(32'd1000, 16'd3);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ir", {31'd0, in_ready}, 32'd1);
        chk("abort_ov", {31'd0, out_valid}, 32'd0);
        chk("abort_q", Q, 32'd0);
        chk("abort_rm", {16'd0, Rm}, 32'd0);
        chk("abort_dz", {31'd0, dz}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("no_ghost", seen, 0);
        issue(32'd1000, 16'd3);
        collect("post_rst", 32'd333, 16'd1, 1'b0, 32 + XL, 0, 1'b0,
                32'd0, 16'd0);

        // Random back-to-back traffic with random output stalls.
        for (int i = 0; i < 20; i++) begin
            rn = $urandom;
            if ($urandom_range(0, 7) == 0)
                rd = 16'd0;
            else if ($urandom_range(0, 1) == 1)
                rd = 16'($urandom_range(1, 255));
            else
                rd = 16'($urandom_range(1, 65535));
            issue(rn, rd);
            collect($sformatf("rnd%0d", i), ref_q(rn, rd), ref_rm(rn, rd),
                    rd == 16'd0, ref_lat(rd), $urandom_range(0, 4), 1'b0,
                    32'd0, 16'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
